// File: rtl/xadc_host_seq.sv
// Host-side XADC sequencer: starts conversions through the control register,
// polls the done flag, reads samples and returns their truncated average.
module xadc_host_seq #(
  parameter int unsigned LOG2_AVG = 2,
  parameter int unsigned TIMEOUT  = 1023,
  parameter int unsigned FLAG_BIT = 9
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        i_req,
  input  logic [7:0]  i_cfg,
  input  logic [31:0] i_bus,
  output logic        o_wr1c,
  output logic [8:0]  o_i_ext,
  output logic        o_sel_mux,
  output logic        o_busy,
  output logic        o_valid,
  output logic [11:0] o_avg,
  output logic        o_timeout
);

  localparam int unsigned ACC_W  = 12 + LOG2_AVG;
  localparam int unsigned SCNT_W = LOG2_AVG + 1;
  localparam int unsigned PCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [SCNT_W-1:0] N_SAMP    = SCNT_W'(2 ** LOG2_AVG);
  localparam logic [PCNT_W-1:0] POLL_LIM  = PCNT_W'(TIMEOUT);
  localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_START = 4'd1;
  localparam logic [3:0] S_POLL     = 4'd2;
  localparam logic [3:0] S_SEL_DATA = 4'd3;
  localparam logic [3:0] S_READ     = 4'd4;
  localparam logic [3:0] S_CLEAR    = 4'd5;
  localparam logic [3:0] S_WAIT_CLR = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_ABORT    = 4'd8;

  logic [3:0]        state, state_d;
  logic [7:0]        cfg, cfg_d;
  logic [ACC_W-1:0]  acc, acc_d;
  logic [SCNT_W-1:0] scnt, scnt_d;
  logic [PCNT_W-1:0] pcnt, pcnt_d;

  logic        wr1c_d, sel_mux_d, busy_d, valid_d, timeout_d;
  logic [8:0]  i_ext_d;
  logic [11:0] avg_d;

  logic flag;
  logic unused_bus;

  assign flag       = i_bus[FLAG_BIT];
  assign unused_bus = ^i_bus;

  // State, datapath and output registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= S_IDLE;
      cfg       <= '0;
      acc       <= '0;
      scnt      <= '0;
      pcnt      <= '0;
      o_wr1c    <= 1'b0;
      o_i_ext   <= '0;
      o_sel_mux <= 1'b1;
      o_busy    <= 1'b0;
      o_valid   <= 1'b0;
      o_avg     <= '0;
      o_timeout <= 1'b0;
    end else begin
      state     <= state_d;
      cfg       <= cfg_d;
      acc       <= acc_d;
      scnt      <= scnt_d;
      pcnt      <= pcnt_d;
      o_wr1c    <= wr1c_d;
      o_i_ext   <= i_ext_d;
      o_sel_mux <= sel_mux_d;
      o_busy    <= busy_d;
      o_valid   <= valid_d;
      o_avg     <= avg_d;
      o_timeout <= timeout_d;
    end
  end

  // Next state plus next-cycle outputs, decoded from the state being entered
  always_comb begin
    state_d = state;
    cfg_d   = cfg;
    acc_d   = acc;
    scnt_d  = scnt;
    pcnt_d  = pcnt;

    case (state)
      S_IDLE: begin
        if (i_req) begin
          cfg_d   = i_cfg;
          acc_d   = '0;
          scnt_d  = '0;
          pcnt_d  = '0;
          state_d = S_WR_START;
        end
      end
      S_WR_START: begin
        pcnt_d  = '0;
        state_d = S_POLL;
      end
      S_POLL: begin
        pcnt_d = pcnt + PCNT_ONE;
        if (flag) begin
          state_d = S_SEL_DATA;
        end else if (pcnt == POLL_LIM) begin
          state_d = S_ABORT;
        end
      end
      S_SEL_DATA: begin
        state_d = S_READ;
      end
      S_READ: begin
        acc_d   = acc + ACC_W'(i_bus[11:0]);
        scnt_d  = scnt + SCNT_ONE;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        pcnt_d  = '0;
        state_d = S_WAIT_CLR;
      end
      S_WAIT_CLR: begin
        // Flag must drop before the next start so a stale done is never reused
        pcnt_d = pcnt + PCNT_ONE;
        if (!flag) begin
          state_d = (scnt == N_SAMP) ? S_DONE : S_WR_START;
        end else if (pcnt == POLL_LIM) begin
          state_d = S_ABORT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ABORT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    wr1c_d    = 1'b0;
    i_ext_d   = o_i_ext;
    sel_mux_d = 1'b1;
    busy_d    = (state_d != S_IDLE);
    valid_d   = 1'b0;
    avg_d     = o_avg;
    timeout_d = 1'b0;

    case (state_d)
      S_WR_START: begin
        wr1c_d  = 1'b1;
        i_ext_d = {cfg_d, 1'b1};
      end
      S_SEL_DATA, S_READ: begin
        sel_mux_d = 1'b0;
      end
      S_CLEAR: begin
        wr1c_d  = 1'b1;
        i_ext_d = {cfg_d, 1'b0};
      end
      S_DONE: begin
        valid_d = 1'b1;
        avg_d   = 12'(acc_d >> LOG2_AVG);
      end
      S_ABORT: begin
        wr1c_d    = 1'b1;
        i_ext_d   = {cfg_d, 1'b0};
        timeout_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_xadc_host_seq.sv
// Bench for xadc_host_seq: three instances (LOG2_AVG 0/2/4) each driven by a
// small peripheral model; averages and aborts are checked from a scoreboard.
module tb_xadc_host_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [2:0]       req;
  logic [2:0][7:0]  cfg;
  wire  [2:0]       wr, sel, busy, vld, tout;
  wire  [2:0][8:0]  ext;
  wire  [2:0][11:0] avg;

  int dly [3];
  int hold [3];
  bit never [3];
  int data [3][16];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          k;
    bit          to;
    logic [11:0] avg;
  } exp_t;

  exp_t sbq [$];
  exp_t ev;

  int starts [3], clears [3], vcnt [3], last_start [3], last_clr [3], gap_min [3];
  logic [8:0] exp_start [3], exp_clr [3];
  int cyc = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 0 : (g == 1) ? 2 : 4;
    localparam int unsigned T = (g == 1) ? 15 : 1023;

    logic [31:0] pbus;
    logic        flag;
    int          cd, hc, idx;

    xadc_host_seq #(.LOG2_AVG(L), .TIMEOUT(T), .FLAG_BIT(9)) u_dut (
      .clk_in   (clk),
      .rst      (rst),
      .i_req    (req[g]),
      .i_cfg    (cfg[g]),
      .i_bus    (pbus),
      .o_wr1c   (wr[g]),
      .o_i_ext  (ext[g]),
      .o_sel_mux(sel[g]),
      .o_busy   (busy[g]),
      .o_valid  (vld[g]),
      .o_avg    (avg[g]),
      .o_timeout(tout[g])
    );

    // Peripheral model: done flag rises after a delay, drops (optionally late) on clear
    always @(posedge clk) begin
      if (rst) begin
        flag <= 1'b0; cd <= 0; hc <= 0; idx <= 0; pbus <= '0;
      end else begin
        if (wr[g] && ext[g][0]) cd <= dly[g] + 1;
        else if (cd > 1) cd <= cd - 1;
        else if (cd == 1) begin
          cd <= 0;
          if (!never[g]) flag <= 1'b1;
        end
        if (wr[g] && !ext[g][0]) begin
          if (hold[g] == 0) flag <= 1'b0;
          else hc <= hold[g];
          idx <= idx + 1;
        end else if (hc > 1) hc <= hc - 1;
        else if (hc == 1) begin
          hc <= 0; flag <= 1'b0;
        end
        if (vld[g] || tout[g]) idx <= 0;
        pbus <= sel[g] ? ((32'(flag) << 9) | 32'(ext[g])) : 32'(data[g][idx & 15]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: write strobes and result events
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (wr[k] && ext[k][0]) begin
          check($sformatf("start_ext%0d", k), 32'(ext[k]), 32'(exp_start[k]));
          if (gap_min[k] > 0 && clears[k] > 0)
            check($sformatf("clr_gap%0d", k), 32'(cyc - last_clr[k] >= gap_min[k]), 32'(1));
          starts[k]++;
          last_start[k] = cyc;
        end
        if (wr[k] && !ext[k][0]) begin
          check($sformatf("clear_ext%0d", k), 32'(ext[k]), 32'(exp_clr[k]));
          clears[k]++;
          last_clr[k] = cyc;
        end
        if (vld[k] || tout[k]) begin
          if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event%0d: got valid=%0b timeout=%0b expected none", k, vld[k], tout[k]);
          end else begin
            ev = sbq.pop_front();
            check("evt_inst", 32'(k), 32'(ev.k));
            check($sformatf("evt_kind%0d", k), 32'(tout[k]), 32'(ev.to));
            check($sformatf("avg%0d", k), 32'(avg[k]), 32'(ev.avg));
            if (tout[k]) check($sformatf("tout_lat%0d", k), 32'(cyc - last_start[k]), 32'(17));
            if (vld[k]) vcnt[k]++;
          end
        end
      end
    end
  end

  task automatic reset_counts();
    for (int k = 0; k < 3; k++) begin
      starts[k] = 0; clears[k] = 0; vcnt[k] = 0;
    end
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy[k] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("idle%0d", k), 32'(busy[k]), 32'(0));
    check("sb_empty", 32'(sbq.size()), 32'(0));
  endtask

  task automatic do_req(input int k, input logic [7:0] c, input int exp_avg, input bit to);
    exp_t e;
    e.k = k; e.to = to; e.avg = 12'(exp_avg);
    sbq.push_back(e);
    @(negedge clk);
    cfg[k] = c;
    req[k] = 1'b1;
    @(negedge clk);
    req[k] = 1'b0;
    wait_idle(k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; req = '0; cfg = '0;
    for (int k = 0; k < 3; k++) begin
      dly[k] = 3; hold[k] = 0; never[k] = 1'b0; gap_min[k] = 0;
      exp_start[k] = '0; exp_clr[k] = '0; last_start[k] = 0; last_clr[k] = 0;
      for (int i = 0; i < 16; i++) data[k][i] = 0;
    end
    reset_counts();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("rst_state%0d", k),
            32'({busy[k], sel[k], wr[k], vld[k], tout[k], ext[k], avg[k]}),
            32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 12'h000}));
    rst = 1'b0;

    // Single sample, cfg 0x5A
    data[0][0] = 32'hABC; exp_start[0] = 9'h0B5; exp_clr[0] = 9'h0B4;
    reset_counts();
    do_req(0, 8'h5A, 'hABC, 1'b0);
    check("t1_starts", 32'(starts[0]), 32'(1));
    check("t1_clears", 32'(clears[0]), 32'(1));
    check("t1_valids", 32'(vcnt[0]), 32'(1));

    // Four-sample average with truncation
    data[1][0] = 'h100; data[1][1] = 'h200; data[1][2] = 'h300; data[1][3] = 'h401;
    exp_start[1] = 9'h067; exp_clr[1] = 9'h066;
    reset_counts();
    do_req(1, 8'h33, 'h280, 1'b0);
    check("t2_starts", 32'(starts[1]), 32'(4));
    check("t2_clears", 32'(clears[1]), 32'(4));

    // Flag held high after each clear write
    data[1][0] = 'h010; data[1][1] = 'h020; data[1][2] = 'h030; data[1][3] = 'h041;
    hold[1] = 5; gap_min[1] = 7;
    reset_counts();
    do_req(1, 8'h33, 'h028, 1'b0);
    check("t3_starts", 32'(starts[1]), 32'(4));
    check("t3_clears", 32'(clears[1]), 32'(4));
    hold[1] = 0; gap_min[1] = 0;

    // Flag never rises: abort after TIMEOUT, previous average retained
    never[1] = 1'b1; exp_start[1] = 9'h003; exp_clr[1] = 9'h002;
    reset_counts();
    do_req(1, 8'h01, 'h028, 1'b1);
    check("t4_starts", 32'(starts[1]), 32'(1));
    check("t4_clears", 32'(clears[1]), 32'(1));
    check("t4_valids", 32'(vcnt[1]), 32'(0));
    never[1] = 1'b0;

    // Reset while polling the second sample
    data[1][0] = 'h004; data[1][1] = 'h008; data[1][2] = 'h00C; data[1][3] = 'h010;
    exp_start[1] = 9'h023; exp_clr[1] = 9'h022;
    reset_counts();
    @(negedge clk);
    cfg[1] = 8'h11; req[1] = 1'b1;
    @(negedge clk);
    req[1] = 1'b0;
    n = 0;
    while (starts[1] < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("t5_second_start", 32'(starts[1] >= 2), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_outputs", 32'({busy[1], sel[1], wr[1], vld[1], tout[1], ext[1]}),
          32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000}));
    rst = 1'b0;
    reset_counts();
    do_req(1, 8'h11, 'h00A, 1'b0);
    check("t5_starts", 32'(starts[1]), 32'(4));

    // Back-to-back requests with i_req held high
    data[0][0] = 'h123; exp_start[0] = 9'h0B5; exp_clr[0] = 9'h0B4;
    reset_counts();
    begin
      exp_t e;
      e.k = 0; e.to = 1'b0; e.avg = 12'h123;
      sbq.push_back(e);
      sbq.push_back(e);
    end
    @(negedge clk);
    cfg[0] = 8'h5A; req[0] = 1'b1;
    n = 0;
    for (int c = 0; c < 500 && n < 2; c++) begin
      @(negedge clk);
      if (vld[0]) n++;
    end
    req[0] = 1'b0;
    wait_idle(0);
    check("t6_valids", 32'(vcnt[0]), 32'(2));
    check("t6_starts", 32'(starts[0]), 32'(2));

    // Sixteen full-scale samples
    for (int i = 0; i < 16; i++) data[2][i] = 'hFFF;
    exp_start[2] = 9'h101; exp_clr[2] = 9'h100;
    reset_counts();
    do_req(2, 8'h80, 'hFFF, 1'b0);
    check("t7_starts", 32'(starts[2]), 32'(16));
    check("t7_clears", 32'(clears[2]), 32'(16));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
